uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART byte transmitter among `NUM_REQ` byte producers. It accepts bytes over valid/ready handshakes and drives the transmitter's one-cycle start pulse. It holds the byte stable for the whole frame and enforces frame spacing by counting cycles, because the transmitter has no busy output. It sits between the application producers (loopback echo, status reporter, debug dump) and the transmitter.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `FRAME_CYCLES`, 4400: clocks reserved per frame after the start pulse. This covers 10 bit times at 436 clk/bit plus guard.
- `CNT_W`, 16: width of the frame wait counter. Must satisfy FRAME_CYCLES < 2^CNT_W.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  grant enable. When low, no new grants are issued; a frame already in progress completes.
- `req_valid`  in  NUM_REQ  per-requester byte-valid.
- `req_data`  in  8*NUM_REQ  byte for requester i, at bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot accept. A transfer occurs when `req_valid[i] & req_ready[i]`.
- `tx_triger_flag`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  8  byte to the transmitter. Held stable from the accept until the next accept.
- `busy`  out  1  high while a frame is in flight (TRIG or WAIT).
- `grant_id`  out  $clog2(NUM_REQ)  index of the last accepted requester.
- `frame_count`  out  16  number of frames started. Wraps 0xFFFF→0x0000.

## Operation
- States:
  - IDLE: may grant.
  - TRIG: start pulse.
  - WAIT: frame countdown.
- IDLE:
  - If `en` and any `req_valid`, pick the winner by round-robin. Search starts at `grant_id+1` modulo NUM_REQ.
  - Assert `req_ready[winner]` combinationally in that cycle.
  - On the clock edge: load `tx_data` with the winner's byte, set `grant_id` to the winner, and move to TRIG.
  - Otherwise `req_ready` is all-zero and the block stays in IDLE.
- TRIG:
  - `tx_triger_flag`=1 for exactly this cycle.
  - `frame_count` increments.
  - Load wait counter with FRAME_CYCLES-1, then move to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - At 0, move to IDLE.
  - `req_ready`=0 throughout.
- `req_ready` is nonzero only in IDLE and is at most one-hot.
- `req_valid` must not depend combinationally on `req_ready`.
- A requester that drops `req_valid` before being granted is simply skipped; there is no latching of requests.
- `en` deasserted in TRIG/WAIT has no effect on the current frame. It blocks only the next grant.
- Reset mid-frame:
  - Next cycle is IDLE with all outputs at reset values.
  - `tx_triger_flag` is never asserted on the cycle after reset.
  - A partially sent frame is abandoned. The transmitter is reset by the same system reset.
- Reset values:
  - `req_ready`=0, `tx_triger_flag`=0, `tx_data`=0x00, `busy`=0, `frame_count`=0.
  - `grant_id`=NUM_REQ-1, so requester 0 has first priority.

## Timing
- Accept at cycle t (IDLE, handshake).
- t+1: TRIG, `tx_triger_flag`=1, `tx_data` valid (registered on edge t).
- t+2 .. t+1+FRAME_CYCLES: WAIT, with `busy`=1 from t+1 through t+1+FRAME_CYCLES.
- Earliest next accept: t+2+FRAME_CYCLES. Back-to-back frames have period FRAME_CYCLES+2.
- Latency from `req_valid` rising in IDLE to accept: 0 cycles.
- Latency from accept to start pulse: 1 cycle.
- `frame_count` updates at the end of the TRIG cycle, i.e. visible at t+2.

## Structure
- Package `uart_ctrl_pkg` holds:
  - the state enum {IDLE, TRIG, WAIT};
  - the constant `UART_FRAME_BITS`=10;
  - the function `frame_cycles(clk_hz, baud)` returning 10*ceil(clk_hz/baud)+guard.
- Sub-module `rr_pick`: combinational round-robin selector.
  - Inputs: request vector and last-grant index.
  - Outputs: one-hot grant, encoded index, and any-valid flag.
- Top level contains the FSM, wait counter, data register and frame counter.

## Test plan
Run with NUM_REQ=4, FRAME_CYCLES=20.
- Reset release with all `req_valid`=0 → all outputs at reset values, and `tx_triger_flag` never pulses for 100 cycles.
- Single byte: `req_valid[2]`=1, data 0x5A → `req_ready[2]` high same cycle; next cycle `tx_triger_flag`=1 and `tx_data`=0x5A; `busy` high 21 cycles; `frame_count`=1.
- Fairness: all four valid continuously with data 0x10..0x13 → grants ordered 0,1,2,3,0, spaced 22 cycles apart.
- `en`=0 during WAIT → current frame completes and `busy` falls; no grant until `en`=1; then grant in the same cycle `en` rises.
- Reset asserted mid-WAIT → next cycle IDLE, `tx_data`=0x00, `grant_id`=3, `busy`=0; the following valid on requester 0 is granted first.
- `frame_count` preset-equivalent run (force 0xFFFF via 65535 frames or backdoor) → next TRIG wraps it to 0x0000.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_ctrl_pkg
// Brief    : Shared state encoding and frame-timing helpers for the UART
//            transmit arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TRIG = 2'd1,
      WAIT = 2'd2
   } state_e;

   localparam int unsigned UART_FRAME_BITS    = 10;
   localparam int unsigned FRAME_GUARD_CYCLES = 40;

   // Clocks per frame: whole bit periods (rounded up) plus a fixed guard.
   function automatic int unsigned frame_cycles(input int unsigned clk_hz,
                                                input int unsigned baud);
      return UART_FRAME_BITS * ((clk_hz + baud - 1) / baud) + FRAME_GUARD_CYCLES;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Bundled valid/ready byte handshake for all requesters.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;

   modport master (
      output req_valid,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin selector; search begins one past the
//            last granted index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  wire logic [NUM_REQ-1:0] req,
   input  wire logic [IDX_W-1:0]   last,
   output logic      [NUM_REQ-1:0] gnt,
   output logic      [IDX_W-1:0]   idx,
   output logic                    any
);

   int               w_pos;
   logic [IDX_W-1:0] w_pos_idx;

   always_comb begin
      gnt       = '0;
      idx       = '0;
      any       = 1'b0;
      w_pos     = 0;
      w_pos_idx = '0;
      // Offset NUM_REQ wraps back to 'last' itself, so it is checked last.
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_pos     = (int'(last) + k) % NUM_REQ;
         w_pos_idx = IDX_W'(w_pos);
         if (!any && req[w_pos_idx]) begin
            any            = 1'b1;
            idx            = w_pos_idx;
            gnt[w_pos_idx] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Shares one UART byte transmitter among NUM_REQ producers, pacing
//            frames by cycle count since the transmitter has no busy output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int FRAME_CYCLES = 4400,
   parameter int CNT_W        = 16
) (
   input  wire logic                       clk,
   input  wire logic                       rst,
   input  wire logic                       en,
   uart_tx_arbiter_if.slave                req,
   output logic                            tx_triger_flag,
   output logic [7:0]                      tx_data,
   output logic                            busy,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id,
   output logic [15:0]                     frame_count
);

   localparam int               c_IDX_W     = $clog2(NUM_REQ);
   localparam logic [1:0]       c_ST_IDLE   = IDLE;
   localparam logic [1:0]       c_ST_TRIG   = TRIG;
   localparam logic [1:0]       c_ST_WAIT   = WAIT;
   localparam logic [CNT_W-1:0] c_WAIT_LOAD = CNT_W'(FRAME_CYCLES - 1);

   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [7:0]         r_tx_data;
   logic [c_IDX_W-1:0] r_grant_id;
   logic [15:0]        r_frame_count;

   logic [NUM_REQ-1:0] w_gnt;
   logic [c_IDX_W-1:0] w_idx;
   logic               w_any;
   logic               w_accept;
   logic [7:0]         w_bytes [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_bytes[gi] = req.req_data[8*gi +: 8];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (c_IDX_W)
   ) u_rr_pick (
      .req  (req.req_valid),
      .last (r_grant_id),
      .gnt  (w_gnt),
      .idx  (w_idx),
      .any  (w_any)
   );

   // Grants are offered only from IDLE, so ready is zero for the whole frame.
   assign w_accept      = (r_state == c_ST_IDLE) && en && w_any;
   assign req.req_ready = w_accept ? w_gnt : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= c_ST_IDLE;
         r_cnt         <= '0;
         r_tx_data     <= 8'h00;
         r_grant_id    <= c_IDX_W'(NUM_REQ - 1);
         r_frame_count <= 16'h0000;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_accept) begin
                  r_tx_data  <= w_bytes[w_idx];
                  r_grant_id <= w_idx;
                  r_state    <= c_ST_TRIG;
               end
            end
            c_ST_TRIG: begin
               r_frame_count <= r_frame_count + 16'd1;
               r_cnt         <= c_WAIT_LOAD;
               r_state       <= c_ST_WAIT;
            end
            c_ST_WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= c_ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   assign tx_triger_flag = (r_state == c_ST_TRIG);
   assign busy           = (r_state != c_ST_IDLE);
   assign tx_data        = r_tx_data;
   assign grant_id       = r_grant_id;
   assign frame_count    = r_frame_count;

endmodule
`default_nettype wire
